operand_hazard_scoreboard: RTL and testbench

- Interlock controller for the operand-fetch (OF) stage of the pipelined SimpleRisc core.
- Tracks destination registers of in-flight instructions (EX, MA, RW) in a shift pipeline.
- Stalls OF whenever the current instruction's effective source registers match a pending write. Rules: ret reads r15, st reads rd as its second operand.
- Inserts bubbles into EX while stalled and counts stall cycles for performance monitoring. No forwarding is provided; the block is pure interlock.

---
 rtl/operand_hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_operand_hazard_scoreboard.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_hazard_scoreboard
//
// Interlock controller for the operand-fetch (OF) stage of the pipelined
// SimpleRisc core. It remembers the destination register of every instruction
// still in flight (EX, MA, RW) and holds OF while the current instruction
// reads one of those registers. The core has no forwarding paths, so this
// block is the only protection against read-after-write hazards.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   of_valid        OF holds a valid instruction
//   of_inst         instruction word in OF (rd=[26:22] rs1=[21:17] rs2=[16:12])
//   of_isRet        ret: source 1 is r15
//   of_isSt         st: source 2 is rd
//   of_isCall       call: writes r15
//   of_useRs1       rs1 is read
//   of_useRs2       rs2 is read (register form)
//   of_writesRd     instruction writes rd
//   flush           taken branch in EX, squash the OF instruction
//   stall           hold PC and the IF/OF latch
//   issue           OF instruction moves into EX this cycle
//   ex_bubble       EX latch loads a nop this cycle
//   hazard_src1/2   per-source conflict flags (debug)
//   stall_count     saturating count of stall cycles
// -----------------------------------------------------------------------------
module operand_hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             of_valid,
  input  logic [31:0]      of_inst,
  input  logic             of_isRet,
  input  logic             of_isSt,
  input  logic             of_isCall,
  input  logic             of_useRs1,
  input  logic             of_useRs2,
  input  logic             of_writesRd,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic             ex_bubble,
  output logic             hazard_src1,
  output logic             hazard_src2,
  output logic [CNT_W-1:0] stall_count
);

  // r15 is the link register used implicitly by call and ret.
  localparam logic [REG_W-1:0] LINK_REG = REG_W'(15);

  // Instruction fields.
  logic [REG_W-1:0] rd, rs1, rs2;
  assign rd  = of_inst[22 +: REG_W];
  assign rs1 = of_inst[17 +: REG_W];
  assign rs2 = of_inst[12 +: REG_W];

  // Effective operands after the ret/st/call special cases.
  logic [REG_W-1:0] src1, src2, dst;
  logic             used1, used2, dvalid;
  assign src1   = of_isRet  ? LINK_REG : rs1;
  assign used1  = of_isRet  | of_useRs1;
  assign src2   = of_isSt   ? rd       : rs2;  // st reads the value register rd
  assign used2  = of_isSt   | of_useRs2;
  assign dst    = of_isCall ? LINK_REG : rd;
  assign dvalid = of_isCall | of_writesRd;

  // Scoreboard: entry 0 is EX, entry DEPTH-1 is RW.
  logic [DEPTH-1:0] sb_v;
  logic [REG_W-1:0] sb_dst [DEPTH];

  // Every entry, including RW, is compared: the register file cannot hand a
  // value written this cycle to a read in the same cycle.
  logic hit1, hit2;
  always_comb begin
    // NOTE: defaults assigned before the loop so no path leaves the flags
    // unassigned; without them synthesis would infer latches.
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v[i] && (sb_dst[i] == src1)) hit1 = 1'b1;
      if (sb_v[i] && (sb_dst[i] == src2)) hit2 = 1'b1;
    end
  end

  assign hazard_src1 = of_valid & used1 & hit1;
  assign hazard_src2 = of_valid & used2 & hit2;
  // A flushed instruction is dropped anyway, so it must not hold the PC.
  assign stall       = (hazard_src1 | hazard_src2) & ~flush;
  assign issue       = of_valid & ~stall & ~flush;
  assign ex_bubble   = ~issue;

  // Valid bits shift every cycle, stalled or not: in-flight instructions keep
  // draining while OF waits.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every entry
    // samples its neighbour's pre-edge value, giving a true shift register.
    if (!rst_n) begin
      sb_v <= '0;
    end else begin
      sb_v[0] <= issue & dvalid;
      for (int i = 1; i < DEPTH; i++) sb_v[i] <= sb_v[i-1];
    end
  end

  // NOTE: the register indices are only meaningful when the matching valid
  // bit is set, so they carry no reset and shift as plain data.
  always_ff @(posedge clk) begin
    sb_dst[0] <= dst;
    for (int i = 1; i < DEPTH; i++) sb_dst[i] <= sb_dst[i-1];
  end

  // Performance counter: saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_operand_hazard_scoreboard
//
// Directed bench for operand_hazard_scoreboard. Two instances share stimulus:
// dut uses the default 16-bit counter, dut_b a 4-bit counter for saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Flag vectors are {stall, issue, ex_bubble, hazard_src1,
// hazard_src2}.
// -----------------------------------------------------------------------------
module tb_operand_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        of_valid, of_isRet, of_isSt, of_isCall;
  logic        of_useRs1, of_useRs2, of_writesRd, flush;
  logic [31:0] of_inst;

  logic        stall, issue, ex_bubble, hazard_src1, hazard_src2;
  logic [15:0] stall_count;
  logic        stall_b, issue_b, ex_bubble_b, hazard_src1_b, hazard_src2_b;
  logic [3:0]  stall_count_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt  = 0;  // model of the 16-bit counter
  int exp_cnt4 = 0;  // model of the 4-bit saturating counter

  always #5 clk = ~clk;

  operand_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_inst(of_inst),
    .of_isRet(of_isRet), .of_isSt(of_isSt), .of_isCall(of_isCall),
    .of_useRs1(of_useRs1), .of_useRs2(of_useRs2), .of_writesRd(of_writesRd),
    .flush(flush), .stall(stall), .issue(issue), .ex_bubble(ex_bubble),
    .hazard_src1(hazard_src1), .hazard_src2(hazard_src2),
    .stall_count(stall_count)
  );

  operand_hazard_scoreboard #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_inst(of_inst),
    .of_isRet(of_isRet), .of_isSt(of_isSt), .of_isCall(of_isCall),
    .of_useRs1(of_useRs1), .of_useRs2(of_useRs2), .of_writesRd(of_writesRd),
    .flush(flush), .stall(stall_b), .issue(issue_b), .ex_bubble(ex_bubble_b),
    .hazard_src1(hazard_src1_b), .hazard_src2(hazard_src2_b),
    .stall_count(stall_count_b)
  );

  function automatic logic [31:0] mk(input int rd_i, input int rs1_i, input int rs2_i);
    logic [31:0] w;
    w        = '0;
    w[26:22] = 5'(rd_i);
    w[21:17] = 5'(rs1_i);
    w[16:12] = 5'(rs2_i);
    return w;
  endfunction

  task automatic drv(input logic v, input logic [31:0] inst, input logic ret,
                     input logic st, input logic call, input logic u1,
                     input logic u2, input logic wr, input logic fl);
    of_valid = v;  of_inst = inst;  of_isRet = ret;  of_isSt = st;
    of_isCall = call;  of_useRs1 = u1;  of_useRs2 = u2;  of_writesRd = wr;
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drv(1'b0, '0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic model_count(input logic s);
    if (s) begin
      exp_cnt++;
      if (exp_cnt4 != 15) exp_cnt4++;
    end
  endtask

  // Reset with independent traffic: no stalls, issue every cycle.
  task automatic test_reset();
    rst_n = 1'b0;
    drv(1'b1, mk(10, 20, 25), 0, 0, 0, 1, 1, 1, 0);
    #2;
    n_cmp++;
    if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want %b", {stall, issue, ex_bubble, hazard_src1, hazard_src2}, 5'b01000);
    end
    n_cmp++;
    if (stall_count !== 16'd0 || stall_count_b !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d/%0d want 0/0", stall_count, stall_count_b);
    end
    #1 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      drv(1'b1, mk(10 + c, 20 + c, 24 + c), 0, 0, 0, 1, 1, 1, 0);
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== 5'b01000) begin
        n_fail++;
        $display("FAIL indep_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, 5'b01000);
      end
      n_cmp++;
      if (stall_count !== 16'd0) begin
        n_fail++;
        $display("FAIL indep_count_c%0d got %0d want 0", c, stall_count);
      end
      tick();
    end
    drain();
  endtask

  // add r1,r2,r3 then sub r4,r1,r5: three stalls then issue.
  task automatic test_raw_hazard();
    logic [4:0] exp [5] = '{5'b01000, 5'b10110, 5'b10110, 5'b10110, 5'b01000};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drv(1'b1, mk(1, 2, 3), 0, 0, 0, 1, 1, 1, 0);
      else        drv(1'b1, mk(4, 1, 5), 0, 0, 0, 1, 1, 1, 0);
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== exp[c]) begin
        n_fail++;
        $display("FAIL raw_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, exp[c]);
      end
      n_cmp++;
      if (stall_count !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL raw_count_c%0d got %0d want %0d", c, stall_count, exp_cnt);
      end
      model_count(exp[c][4]);
      tick();
    end
    drain();
  endtask

  // call then ret (r15 via of_isRet), then call then a plain read of r15.
  task automatic test_call_ret();
    logic [4:0] exp [5] = '{5'b01000, 5'b10110, 5'b10110, 5'b10110, 5'b01000};
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (c == 0)      drv(1'b1, mk(3, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        else if (r == 0) drv(1'b1, mk(0, 0, 0), 1, 0, 0, 0, 0, 0, 0);
        else             drv(1'b1, mk(0, 15, 0), 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== exp[c]) begin
          n_fail++;
          $display("FAIL callret_r%0d_c%0d got %b want %b", r, c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, exp[c]);
        end
        model_count(exp[c][4]);
        tick();
      end
      drain();
    end
    n_cmp++;
    if (stall_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL callret_count got %0d want %0d", stall_count, exp_cnt);
    end
  endtask

  // add r5 then st r5,[r6]: source 2 is rd. Then immediate-form no-hazard.
  task automatic test_store_and_imm();
    logic [4:0] exp [5] = '{5'b01000, 5'b10101, 5'b10101, 5'b10101, 5'b01000};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drv(1'b1, mk(5, 1, 2), 0, 0, 0, 1, 1, 1, 0);
      else        drv(1'b1, mk(5, 6, 0), 0, 1, 0, 1, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== exp[c]) begin
        n_fail++;
        $display("FAIL store_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, exp[c]);
      end
      model_count(exp[c][4]);
      tick();
    end
    drain();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drv(1'b1, mk(7, 1, 0), 0, 0, 0, 1, 0, 1, 0);
      else        drv(1'b1, mk(8, 9, 7), 0, 0, 0, 1, 0, 1, 0);
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== 5'b01000) begin
        n_fail++;
        $display("FAIL imm_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, 5'b01000);
      end
      tick();
    end
    drain();
  endtask

  // Flush in the middle of a stall: dropped, no entry, stall resumes.
  task automatic test_flush();
    logic [4:0] exp [5] = '{5'b01000, 5'b10110, 5'b00110, 5'b10110, 5'b01000};
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       drv(1'b1, mk(2, 1, 1),   0, 0, 0, 1, 1, 1, 0);
        2:       drv(1'b1, mk(20, 2, 3),  0, 0, 0, 1, 1, 1, 1);
        4:       drv(1'b1, mk(21, 20, 2), 0, 0, 0, 1, 1, 1, 0);
        default: drv(1'b1, mk(9, 2, 3),   0, 0, 0, 1, 1, 1, 0);
      endcase
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== exp[c]) begin
        n_fail++;
        $display("FAIL flush_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, exp[c]);
      end
      n_cmp++;
      if (stall_count !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL flush_count_c%0d got %0d want %0d", c, stall_count, exp_cnt);
      end
      model_count(exp[c][4]);
      tick();
    end
    drain();
  endtask

  // of_valid=0 masks a real conflict; the same read then stalls when valid.
  task automatic test_idle();
    logic [4:0] exp [3] = '{5'b01000, 5'b00100, 5'b10110};
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drv(1'b1, mk(3, 1, 1), 0, 0, 0, 1, 1, 1, 0);
      else        drv(c == 2, mk(4, 3, 6), 0, 0, 0, 1, 1, 1, 0);
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== exp[c]) begin
        n_fail++;
        $display("FAIL idle_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, exp[c]);
      end
      model_count(exp[c][4]);
      tick();
    end
    drain();
  endtask

  // Asynchronous reset in the middle of a stall clears entries and counter.
  task automatic test_reset_midstall();
    logic [4:0] exp [3] = '{5'b01000, 5'b10111, 5'b10111};
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drv(1'b1, mk(4, 1, 1), 0, 0, 0, 1, 1, 1, 0);
      else        drv(1'b1, mk(6, 4, 4), 0, 0, 0, 1, 1, 1, 0);
      @(negedge clk);
      n_cmp++;
      if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== exp[c]) begin
        n_fail++;
        $display("FAIL midstall_c%0d got %b want %b", c, {stall, issue, ex_bubble, hazard_src1, hazard_src2}, exp[c]);
      end
      model_count(exp[c][4]);
      tick();
    end
    rst_n = 1'b0;
    #1;
    exp_cnt  = 0;
    exp_cnt4 = 0;
    n_cmp++;
    if ({stall, issue, ex_bubble, hazard_src1, hazard_src2} !== 5'b01000) begin
      n_fail++;
      $display("FAIL midstall_reset_flags got %b want %b", {stall, issue, ex_bubble, hazard_src1, hazard_src2}, 5'b01000);
    end
    n_cmp++;
    if (stall_count !== 16'd0 || stall_count_b !== 4'd0) begin
      n_fail++;
      $display("FAIL midstall_reset_count got %0d/%0d want 0/0", stall_count, stall_count_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drain();
  endtask

  // Chain of self-dependent adds: 21 stalls in 28 cycles; 4-bit stops at 15.
  task automatic test_saturation();
    logic [4:0] e;
    for (int c = 0; c < 28; c++) begin
      drv(1'b1, mk(1, 1, 1), 0, 0, 0, 1, 1, 1, 0);
      e = ((c % 4) == 0) ? 5'b01000 : 5'b10111;
      @(negedge clk);
      n_cmp++;
      if ({stall_b, issue_b, ex_bubble_b, hazard_src1_b, hazard_src2_b} !== e) begin
        n_fail++;
        $display("FAIL sat_flags_c%0d got %b want %b", c, {stall_b, issue_b, ex_bubble_b, hazard_src1_b, hazard_src2_b}, e);
      end
      n_cmp++;
      if (stall_count_b !== 4'(exp_cnt4) || stall_count !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_count_c%0d got %0d/%0d want %0d/%0d", c, stall_count, stall_count_b, exp_cnt, exp_cnt4);
      end
      model_count(e[4]);
      tick();
    end
    drv(1'b0, '0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (stall_count_b !== 4'd15 || stall_count !== 16'd21) begin
      n_fail++;
      $display("FAIL sat_final got %0d/%0d want 21/15", stall_count, stall_count_b);
    end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_call_ret();
    test_store_and_imm();
    test_flush();
    test_idle();
    test_reset_midstall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
